// File: rtl/x9_pkg.sv
// Shared types and constants for the X9 run-control sequencer.
// The X9_HALT constant only takes effect when the build defines X9_HALT_EN.
package x9_pkg;

    localparam int unsigned X9_IW     = 9;
    localparam int unsigned X9_D_DEF  = 12;
    localparam int unsigned X9_LA_DEF = 4;
    localparam int unsigned X9_CW_DEF = 16;

    localparam logic [X9_IW-1:0] X9_HALT = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_t;

endpackage

// File: rtl/x9_run_seq_if.sv
// Bus interface between the X9 run sequencer and the core, ROM and host.
// The master modport is the host side; the slave modport is the sequencer side.
interface x9_run_seq_if #(
    parameter int unsigned D  = 12,
    parameter int unsigned LA = 4,
    parameter int unsigned CW = 16
);
    import x9_pkg::*;

    logic                req;
    logic [D-1:0]        start_addr;
    logic [D-1:0]        end_addr;
    logic [X9_IW-1:0]    mach_code;
    logic                branch_inst;
    logic                one_i;
    logic                pari_i;
    logic                sc_o_i;
    logic                sc_clr;
    logic                sc_en;
    logic                lut_we;
    logic [LA-1:0]       lut_waddr;
    logic [D-1:0]        lut_wdata;

    logic [D-1:0]        prog_ctr;
    logic                step_en;
    logic                sc_q;
    logic                pari_q;
    logic                one_q;
    logic                busy;
    logic                done;
    logic [CW-1:0]       cycle_cnt;

    modport master (
        output req, start_addr, end_addr, mach_code, branch_inst,
               one_i, pari_i, sc_o_i, sc_clr, sc_en,
               lut_we, lut_waddr, lut_wdata,
        input  prog_ctr, step_en, sc_q, pari_q, one_q, busy, done, cycle_cnt
    );

    modport slave (
        input  req, start_addr, end_addr, mach_code, branch_inst,
               one_i, pari_i, sc_o_i, sc_clr, sc_en,
               lut_we, lut_waddr, lut_wdata,
        output prog_ctr, step_en, sc_q, pari_q, one_q, busy, done, cycle_cnt
    );

endinterface

// File: rtl/x9_branch_lut.sv
// Writable branch-target table: posedge write, combinational read, async clear.
// A read of the entry being written in the same cycle returns the old value.
module x9_branch_lut #(
    parameter int unsigned D  = 12,
    parameter int unsigned LA = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [LA-1:0] waddr,
    input  logic [D-1:0]  wdata,
    input  logic [LA-1:0] raddr,
    output logic [D-1:0]  rdata
);

    localparam int unsigned DEPTH = 2 ** LA;

    logic [D-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/x9_run_seq.sv
// X9 run-control/fetch sequencer: PC, branch LUT, lagging ALU flags, req/done handshake.
// Define X9_HALT_EN to make mach_code == X9_HALT end a run early.
module x9_run_seq
    import x9_pkg::*;
#(
    parameter int unsigned D  = X9_D_DEF,
    parameter int unsigned LA = X9_LA_DEF,
    parameter int unsigned CW = X9_CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    x9_run_seq_if.slave   bus
);

`ifdef X9_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    run_state_t     state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sc_q, sc_d;
    logic           pari_q, pari_d;
    logic           one_q, one_d;
    logic           busy_q, done_q;
    logic           step_c;
    logic           halt_c;
    logic [D-1:0]   lut_rdata;

    x9_branch_lut #(.D(D), .LA(LA)) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (bus.lut_we),
        .waddr (bus.lut_waddr),
        .wdata (bus.lut_wdata),
        .raddr (bus.mach_code[LA-1:0]),
        .rdata (lut_rdata)
    );

    assign halt_c = HALT_EN && (bus.mach_code == X9_HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            sc_q    <= 1'b0;
            pari_q  <= 1'b0;
            one_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
            pari_q  <= pari_d;
            one_q   <= one_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    // Next state, PC mux, saturating counter and flag capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        sc_d    = sc_q;
        pari_d  = pari_q;
        one_d   = one_q;
        step_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    pc_d    = bus.start_addr;
                    cnt_d   = '0;
                    sc_d    = 1'b0;
                    pari_d  = 1'b0;
                    one_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((pc_q == bus.end_addr) || halt_c) begin
                    state_d = DONE;
                end else begin
                    step_c = 1'b1;
                    if (cnt_q != {CW{1'b1}}) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    // one_q is the flag of the previously executed instruction.
                    pc_d   = (bus.branch_inst && one_q) ? lut_rdata : pc_q + D'(1);
                    pari_d = bus.pari_i;
                    one_d  = bus.one_i;
                    if (bus.sc_clr) begin
                        sc_d = 1'b0;
                    end else if (bus.sc_en) begin
                        sc_d = bus.sc_o_i;
                    end
                end
            end
            DONE: begin
                if (!bus.req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.prog_ctr  = pc_q;
    assign bus.step_en   = step_c;
    assign bus.sc_q      = sc_q;
    assign bus.pari_q    = pari_q;
    assign bus.one_q     = one_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_x9_run_seq.sv
// Directed bench for x9_run_seq; expected values are hand-computed per step.
// Halt-related expectations follow X9_HALT_EN when the bench is built with it.
module tb_x9_run_seq;
    import x9_pkg::*;

    localparam int unsigned D  = 12;
    localparam int unsigned LA = 4;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    x9_run_seq_if #(.D(D), .LA(LA), .CW(CW)) bus ();

    x9_run_seq #(.D(D), .LA(LA), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_lut(input logic [LA-1:0] a, input logic [D-1:0] d);
        bus.lut_we    = 1'b1;
        bus.lut_waddr = a;
        bus.lut_wdata = d;
        tick();
        bus.lut_we    = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles && bus.done !== 1'b1; i++) begin
            tick();
        end
        chk1("wait_done", bus.done, 1'b1);
    endtask

    int wrap_pc [4] = '{4094, 4095, 0, 1};

    initial begin
        bus.req = 1'b0;         bus.start_addr = '0;   bus.end_addr = '0;
        bus.mach_code = '0;     bus.branch_inst = 1'b0;
        bus.one_i = 1'b0;       bus.pari_i = 1'b0;     bus.sc_o_i = 1'b0;
        bus.sc_clr = 1'b0;      bus.sc_en = 1'b0;
        bus.lut_we = 1'b0;      bus.lut_waddr = '0;    bus.lut_wdata = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #5;
        chkn("rst_pc", 32'(bus.prog_ctr), 0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk1("rst_step", bus.step_en, 1'b0);
        chkn("rst_cnt", 32'(bus.cycle_cnt), 0);
        chk1("rst_flags", bus.sc_q | bus.pari_q | bus.one_q, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Basic run 0..5
        bus.start_addr = 12'd0; bus.end_addr = 12'd5; bus.req = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chkn("t1_pc", 32'(bus.prog_ctr), i);
            chk1("t1_step", bus.step_en, 1'b1);
            tick();
        end
        chkn("t1_pc_end", 32'(bus.prog_ctr), 5);
        chk1("t1_step_end", bus.step_en, 1'b0);
        chk1("t1_busy", bus.busy, 1'b1);
        tick();
        chk1("t1_done", bus.done, 1'b1);
        chkn("t1_cnt", 32'(bus.cycle_cnt), 5);
        chkn("t1_pc_hold", 32'(bus.prog_ctr), 5);
        tick();
        chk1("t1_done_held", bus.done, 1'b1);
        bus.req = 1'b0;
        tick();
        chk1("t1_idle_done", bus.done, 1'b0);
        chk1("t1_idle_busy", bus.busy, 1'b0);

        // Taken branch via lut[3]=40
        wr_lut(4'd3, 12'd40);
        bus.start_addr = 12'd2; bus.end_addr = 12'd41; bus.req = 1'b1;
        tick();
        chkn("t2_pc2", 32'(bus.prog_ctr), 2);
        bus.one_i = 1'b1;
        tick();
        chkn("t2_pc3", 32'(bus.prog_ctr), 3);
        chk1("t2_one_q", bus.one_q, 1'b1);
        bus.one_i = 1'b0; bus.branch_inst = 1'b1; bus.mach_code = 9'h003;
        tick();
        chkn("t2_taken", 32'(bus.prog_ctr), 40);
        bus.branch_inst = 1'b0; bus.mach_code = 9'h000;
        tick();
        chkn("t2_pc41", 32'(bus.prog_ctr), 41);
        chk1("t2_step_end", bus.step_en, 1'b0);
        bus.one_i = 1'b1;
        tick();
        chk1("t2_done", bus.done, 1'b1);
        chkn("t2_cnt", 32'(bus.cycle_cnt), 3);
        chk1("t2_flag_blocked", bus.one_q, 1'b0);
        bus.one_i = 1'b0; bus.req = 1'b0;
        tick();

        // Not-taken branch
        bus.start_addr = 12'd2; bus.end_addr = 12'd5; bus.req = 1'b1;
        tick();
        tick();
        bus.branch_inst = 1'b1; bus.mach_code = 9'h003;
        tick();
        chkn("t2_not_taken", 32'(bus.prog_ctr), 4);
        bus.branch_inst = 1'b0; bus.mach_code = 9'h000;
        tick();
        tick();
        chk1("t2n_done", bus.done, 1'b1);
        chkn("t2n_cnt", 32'(bus.cycle_cnt), 3);
        bus.req = 1'b0;
        tick();

        // Wrap-around run and handshake
        bus.start_addr = 12'd4094; bus.end_addr = 12'd1; bus.req = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chkn("t3_wrap_pc", 32'(bus.prog_ctr), 32'(wrap_pc[k]));
            tick();
        end
        chk1("t3_done", bus.done, 1'b1);
        chkn("t3_cnt", 32'(bus.cycle_cnt), 3);
        tick();
        tick();
        chk1("t3_done_held", bus.done, 1'b1);
        bus.req = 1'b0;
        tick();
        chk1("t3_idle_done", bus.done, 1'b0);
        chk1("t3_idle_busy", bus.busy, 1'b0);

        // Zero-length run
        bus.start_addr = 12'd7; bus.end_addr = 12'd7; bus.req = 1'b1;
        tick();
        chk1("t3z_busy", bus.busy, 1'b1);
        chk1("t3z_step", bus.step_en, 1'b0);
        tick();
        chk1("t3z_done", bus.done, 1'b1);
        chkn("t3z_cnt", 32'(bus.cycle_cnt), 0);
        chkn("t3z_pc", 32'(bus.prog_ctr), 7);
        bus.req = 1'b0;
        tick();

        // Carry register
        bus.start_addr = 12'd0; bus.end_addr = 12'd20; bus.req = 1'b1;
        tick();
        bus.sc_en = 1'b1; bus.sc_o_i = 1'b1;
        tick();
        chk1("t4_load", bus.sc_q, 1'b1);
        bus.sc_clr = 1'b1;
        tick();
        chk1("t4_clr_wins", bus.sc_q, 1'b0);
        bus.sc_clr = 1'b0;
        tick();
        chk1("t4_reload", bus.sc_q, 1'b1);
        bus.sc_en = 1'b0; bus.sc_o_i = 1'b0;
        chkn("t4_pc3", 32'(bus.prog_ctr), 3);

        // Async reset mid-run at PC 3
        reset = 1'b0;
        #1;
        chkn("t5_pc", 32'(bus.prog_ctr), 0);
        chk1("t5_busy", bus.busy, 1'b0);
        chk1("t5_step", bus.step_en, 1'b0);
        chk1("t5_sc", bus.sc_q, 1'b0);
        chkn("t5_cnt", 32'(bus.cycle_cnt), 0);
        bus.req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        bus.start_addr = 12'd2; bus.end_addr = 12'd5; bus.req = 1'b1;
        tick();
        bus.one_i = 1'b1;
        tick();
        bus.one_i = 1'b0; bus.branch_inst = 1'b1; bus.mach_code = 9'h003;
        tick();
        chkn("t5_lut_cleared", 32'(bus.prog_ctr), 0);
        bus.branch_inst = 1'b0; bus.mach_code = 9'h000;
        wait_done(20);
        chkn("t5_cnt_run", 32'(bus.cycle_cnt), 7);
        chkn("t5_pc_end", 32'(bus.prog_ctr), 5);
        bus.req = 1'b0;
        tick();

        // Halt opcode at PC 2
        bus.start_addr = 12'd0; bus.end_addr = 12'd10; bus.req = 1'b1;
        tick();
        for (int i = 0; i < 30 && bus.done !== 1'b1; i++) begin
            bus.mach_code = (bus.prog_ctr == 12'd2) ? X9_HALT : 9'h000;
            tick();
        end
        bus.mach_code = 9'h000;
        chk1("t6_done", bus.done, 1'b1);
`ifdef X9_HALT_EN
        chkn("t6_pc", 32'(bus.prog_ctr), 2);
        chkn("t6_cnt", 32'(bus.cycle_cnt), 2);
`else
        chkn("t6_pc", 32'(bus.prog_ctr), 10);
        chkn("t6_cnt", 32'(bus.cycle_cnt), 10);
`endif
        bus.req = 1'b0;
        tick();
        chk1("t6_idle", bus.done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
